// File: rtl/aludec_seq.sv
// rtl/aludec_seq.sv - sequential ALU control decoder with valid/ready handshake
// Optional feature: define ALUDEC_SEQ_MULDIV_EN to decode mult/div as multi-cycle ops.
module aludec_seq #(
  parameter int CTRL_W      = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic [1:0]        aluop,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              illegal,
  output logic              mc_busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, OUT = 2'd2} state_t;

  state_t     state, state_nxt;
  logic [3:0] dec_ctrl;
  logic       dec_ill;
  logic       dec_mc;
  logic       accept;

  // Out-of-range parameter settings elaborate this empty marker block.
  if (CTRL_W < 4 || MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_params
  end

`ifdef ALUDEC_SEQ_MULDIV_EN
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dec_cnt;
`endif

  // Unlisted encodings fall through to the illegal, single-cycle default.
  always_comb begin
    dec_ctrl = 4'b0000;
    dec_ill  = 1'b1;
    dec_mc   = 1'b0;
`ifdef ALUDEC_SEQ_MULDIV_EN
    dec_cnt  = '0;
`endif
    case (aluop)
      2'b00: begin dec_ctrl = 4'b0010; dec_ill = 1'b0; end
      2'b01: begin dec_ctrl = 4'b1010; dec_ill = 1'b0; end
      2'b10: begin
        case (funct)
          6'b100000: begin dec_ctrl = 4'b0010; dec_ill = 1'b0; end
          6'b100010: begin dec_ctrl = 4'b1010; dec_ill = 1'b0; end
          6'b100100: begin dec_ctrl = 4'b0000; dec_ill = 1'b0; end
          6'b100101: begin dec_ctrl = 4'b0001; dec_ill = 1'b0; end
          6'b101010: begin dec_ctrl = 4'b1011; dec_ill = 1'b0; end
          6'b000110: begin dec_ctrl = 4'b0110; dec_ill = 1'b0; end
`ifdef ALUDEC_SEQ_MULDIV_EN
          6'b011000: begin
            dec_ctrl = 4'b1100; dec_ill = 1'b0; dec_mc = 1'b1;
            dec_cnt  = CNT_W'(MULT_CYCLES - 1);
          end
          6'b011010: begin
            dec_ctrl = 4'b1101; dec_ill = 1'b0; dec_mc = 1'b1;
            dec_cnt  = CNT_W'(DIV_CYCLES - 1);
          end
`endif
          default: ;
        endcase
      end
      2'b11: begin
        case (op)
          6'b001110: begin dec_ctrl = 4'b0100; dec_ill = 1'b0; end
          6'b001111: begin dec_ctrl = 4'b0101; dec_ill = 1'b0; end
          6'b011101: begin dec_ctrl = 4'b0010; dec_ill = 1'b0; end
          6'b010001: begin dec_ctrl = 4'b0111; dec_ill = 1'b0; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = ~flush & ((state == IDLE) | ((state == OUT) & out_ready));
    accept    = in_valid & in_ready;
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_nxt = dec_mc ? EXEC : OUT;
`ifdef ALUDEC_SEQ_MULDIV_EN
        EXEC: if (cnt == '0) state_nxt = OUT;
`else
        EXEC: state_nxt = IDLE;
`endif
        // Retire and accept in the same cycle keeps back-to-back ops bubble-free.
        OUT: if (out_ready) state_nxt = accept ? (dec_mc ? EXEC : OUT) : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      alucontrol <= '0;
      illegal    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alucontrol <= CTRL_W'(dec_ctrl);
        illegal    <= dec_ill;
      end
    end
  end

`ifdef ALUDEC_SEQ_MULDIV_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= dec_mc ? dec_cnt : '0;
    end else if (state == EXEC && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign mc_busy = (state == EXEC);
`else
  assign mc_busy = 1'b0;
`endif

  assign out_valid = (state == OUT);

endmodule

// File: tb/tb_aludec_seq.sv
// tb/tb_aludec_seq.sv - directed self-checking bench for aludec_seq with result scoreboard
module tb_aludec_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_ready, flush, out_valid, out_ready, illegal, mc_busy;
  logic [5:0] op, funct;
  logic [1:0] aluop;
  logic [3:0] alucontrol;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [4:0] sb_q[$];
  logic [4:0] sb_exp;

  logic [1:0] t_a[8] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10};
  logic [5:0] t_o[8] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'b001111, 6'b011101, 6'b010001, 6'd0};
  logic [5:0] t_f[8] = '{6'd0, 6'b100100, 6'b101010, 6'b000110, 6'd0, 6'd0, 6'd0, 6'b000000};

  always #5 clk = ~clk;

  aludec_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .funct      (funct),
    .aluop      (aluop),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .mc_busy    (mc_busy)
  );

  // Returns {illegal, alucontrol}.
  function automatic logic [4:0] ref_dec(input logic [1:0] a, input logic [5:0] o,
                                         input logic [5:0] f);
    logic [4:0] r;
    r = 5'b1_0000;
    case (a)
      2'b00: r = 5'b0_0010;
      2'b01: r = 5'b0_1010;
      2'b10: begin
        case (f)
          6'b100000: r = 5'b0_0010;
          6'b100010: r = 5'b0_1010;
          6'b100100: r = 5'b0_0000;
          6'b100101: r = 5'b0_0001;
          6'b101010: r = 5'b0_1011;
          6'b000110: r = 5'b0_0110;
`ifdef ALUDEC_SEQ_MULDIV_EN
          6'b011000: r = 5'b0_1100;
          6'b011010: r = 5'b0_1101;
`endif
          default:   r = 5'b1_0000;
        endcase
      end
      default: begin
        case (o)
          6'b001110: r = 5'b0_0100;
          6'b001111: r = 5'b0_0101;
          6'b011101: r = 5'b0_0010;
          6'b010001: r = 5'b0_0111;
          default:   r = 5'b1_0000;
        endcase
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [1:0] a, input logic [5:0] o,
                     input logic [5:0] f, input logic r, input logic fl);
    in_valid  = v;
    aluop     = a;
    op        = o;
    funct     = f;
    out_ready = r;
    flush     = fl;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset_n || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          sb_exp = sb_q.pop_front();
          chk("sb_alucontrol", alucontrol, sb_exp[3:0]);
          chk("sb_illegal", illegal, sb_exp[4]);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(ref_dec(aluop, op, funct));
    end
  end

  initial begin
    reset_n = 1'b0;
    drv(0, 2'b00, 6'd0, 6'd0, 0, 0);
    cyc(); cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mc_busy", mc_busy, 0);
    chk("rst_alucontrol", alucontrol, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;

    // single sub, latency 1, valid for one cycle
    drv(1, 2'b10, 6'd0, 6'b100010, 1, 0);
    chk("sub_in_ready", in_ready, 1);
    cyc();
    drv(0, 2'b00, 6'd0, 6'd0, 1, 0);
    chk("sub_out_valid", out_valid, 1);
    chk("sub_alucontrol", alucontrol, 4'b1010);
    chk("sub_illegal", illegal, 0);
    cyc();
    chk("sub_one_cycle", out_valid, 0);

    // add, or, xori back to back
    drv(1, 2'b00, 6'd0, 6'd0, 1, 0);
    cyc();
    drv(1, 2'b10, 6'd0, 6'b100101, 1, 0);
    chk("b2b_in_ready0", in_ready, 1);
    chk("b2b_valid0", out_valid, 1);
    chk("b2b_ctrl0", alucontrol, 4'b0010);
    cyc();
    drv(1, 2'b11, 6'b001110, 6'd0, 1, 0);
    chk("b2b_in_ready1", in_ready, 1);
    chk("b2b_valid1", out_valid, 1);
    chk("b2b_ctrl1", alucontrol, 4'b0001);
    cyc();
    drv(0, 2'b00, 6'd0, 6'd0, 1, 0);
    chk("b2b_valid2", out_valid, 1);
    chk("b2b_ctrl2", alucontrol, 4'b0100);
    cyc();
    chk("b2b_drain", out_valid, 0);

    // remaining decode table streamed through the scoreboard
    for (int i = 0; i < 8; i++) begin
      drv(1, t_a[i], t_o[i], t_f[i], 1, 0);
      chk("tbl_in_ready", in_ready, 1);
      cyc();
    end
    drv(0, 2'b00, 6'd0, 6'd0, 1, 0);
    cyc();
    chk("tbl_drain", out_valid, 0);

    // illegal op held while consumer stalls; new request ignored
    drv(1, 2'b11, 6'b000000, 6'b100000, 0, 0);
    cyc();
    drv(1, 2'b01, 6'd0, 6'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_ctrl", alucontrol, 4'b0000);
      chk("hold_illegal", illegal, 1);
      chk("hold_in_ready", in_ready, 0);
      cyc();
    end
    drv(0, 2'b00, 6'd0, 6'd0, 1, 0);
    chk("hold_release_valid", out_valid, 1);
    cyc();
    chk("hold_done", out_valid, 0);

    // flush in OUT beats in_valid and out_ready
    drv(1, 2'b00, 6'd0, 6'd0, 0, 0);
    cyc();
    drv(1, 2'b01, 6'd0, 6'd0, 1, 1);
    chk("flush_in_ready", in_ready, 0);
    chk("flush_pre_valid", out_valid, 1);
    cyc();
    drv(0, 2'b00, 6'd0, 6'd0, 0, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_ctrl_kept", alucontrol, 4'b0010);
    chk("flush_idle_ready", in_ready, 1);
    chk("flush_mc_busy", mc_busy, 0);
    cyc();
    chk("flush_not_accepted", out_valid, 0);

    // mult
    drv(1, 2'b10, 6'd0, 6'b011000, 1, 0);
    cyc();
`ifdef ALUDEC_SEQ_MULDIV_EN
    drv(1, 2'b00, 6'd0, 6'd0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("mult_busy", mc_busy, 1);
      chk("mult_valid_low", out_valid, 0);
      chk("mult_in_ready", in_ready, 0);
      cyc();
    end
    drv(0, 2'b00, 6'd0, 6'd0, 1, 0);
    chk("mult_out_valid", out_valid, 1);
    chk("mult_busy_done", mc_busy, 0);
    chk("mult_ctrl", alucontrol, 4'b1100);
    chk("mult_illegal", illegal, 0);
`else
    drv(0, 2'b00, 6'd0, 6'd0, 1, 0);
    chk("mult_ill_valid", out_valid, 1);
    chk("mult_ill_ctrl", alucontrol, 4'b0000);
    chk("mult_ill_flag", illegal, 1);
    chk("mult_ill_busy", mc_busy, 0);
`endif
    cyc();
    chk("mult_retired", out_valid, 0);

    // reset in the middle of a div (or its illegal result without mult/div)
    drv(1, 2'b10, 6'd0, 6'b011010, 0, 0);
    cyc();
    drv(0, 2'b00, 6'd0, 6'd0, 0, 0);
    cyc();
`ifdef ALUDEC_SEQ_MULDIV_EN
    chk("div_busy", mc_busy, 1);
`else
    chk("div_ill_valid", out_valid, 1);
`endif
    reset_n = 1'b0;
    #1;
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_mc_busy", mc_busy, 0);
    chk("rstmid_ctrl", alucontrol, 0);
    chk("rstmid_illegal", illegal, 0);
    cyc();
    reset_n = 1'b1;
    drv(1, 2'b00, 6'd0, 6'd0, 1, 0);
    chk("post_rst_in_ready", in_ready, 1);
    cyc();
    drv(0, 2'b00, 6'd0, 6'd0, 1, 0);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_ctrl", alucontrol, 4'b0010);
    cyc();
    cyc();
    chk("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
